// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: run/stop and ratio controller producing a glitch-free divided clock.
// Optional `period_cnt` output enabled by defining CLKDIV_PERIOD_CNT_EN.
module clkdiv_ctrl #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 4,
    parameter int MIN_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div,
    output logic             err
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_t;
    state_t state, nxt_state;
    logic [CNT_W-1:0] cnt, pend, nxt_cnt, nxt_div, nxt_pend;
    logic xfer, legal, wrap, nxt_err, nxt_clk, nxt_tick;
    // pend always holds the ratio to load at the next boundary (equals cur_div when nothing is pending)
    always_comb begin
        cfg_ready = state == IDLE || state == RUN;
        busy      = state != IDLE;
        xfer      = cfg_valid && cfg_ready;
        legal     = cfg_div >= CNT_W'(MIN_DIV);
        wrap      = busy && cnt == cur_div - CNT_W'(1);
        nxt_err   = err || (xfer && !legal);
        nxt_state = state;
        nxt_div   = cur_div;
        nxt_pend  = pend;
        nxt_cnt   = wrap ? '0 : cnt + CNT_W'(1);
        case (state)
            IDLE: begin
                nxt_cnt = '0;
                if (xfer && legal) begin
                    nxt_div  = cfg_div;
                    nxt_pend = cfg_div;
                end
                if (en) nxt_state = RUN;
            end
            RUN: begin
                if (xfer && legal && !wrap) begin
                    nxt_pend  = cfg_div;
                    nxt_state = PEND;
                end else if (xfer && legal) begin
                    nxt_div   = cfg_div;
                    nxt_pend  = cfg_div;
                    nxt_state = en ? RUN : IDLE;
                end else if (wrap) begin
                    nxt_div   = pend;
                    nxt_state = en ? RUN : IDLE;
                end else if (!en) nxt_state = STOP;
            end
            PEND: begin
                if (wrap) begin
                    nxt_div   = pend;
                    nxt_state = en ? RUN : IDLE;
                end else if (!en) nxt_state = STOP;
            end
            STOP: begin
                if (wrap) begin
                    nxt_div   = pend;
                    nxt_state = IDLE;
                end else if (en) nxt_state = RUN;
            end
            default: nxt_state = IDLE;
        endcase
        nxt_clk  = nxt_state != IDLE && nxt_cnt < (nxt_div >> 1);
        nxt_tick = nxt_state != IDLE && nxt_cnt == '0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_div <= CNT_W'(DEF_DIV);
            pend    <= CNT_W'(DEF_DIV);
            clk_out <= 1'b0;
            tick    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            cur_div <= nxt_div;
            pend    <= nxt_pend;
            clk_out <= nxt_clk;
            tick    <= nxt_tick;
            err     <= nxt_err;
        end
    end
`ifdef CLKDIV_PERIOD_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) period_cnt <= '0;
        else if (nxt_tick && period_cnt != 16'hFFFF) period_cnt <= period_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: vector table, corner sequences and randomized run against a reference model.
module tb_clkdiv_ctrl;
    logic       clk = 1'b0, reset = 1'b0, en = 1'b0, cfg_valid = 1'b0;
    logic [7:0] cfg_div = '0;
    logic       cfg_ready, clk_out, tick, busy, err;
    logic [7:0] cur_div;
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif
    always #5 clk = ~clk;

    clkdiv_ctrl dut (
        .clk(clk), .reset(reset), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .clk_out(clk_out), .tick(tick), .busy(busy),
        .cur_div(cur_div), .err(err)
`ifdef CLKDIV_PERIOD_CNT_EN
        , .period_cnt(period_cnt)
`endif
    );

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 running, 2 ratio pending, 3 stopping
    int m_mode, m_cnt, m_div, m_pend;
    bit m_err;

    function automatic bit m_ready();
        return m_mode == 0 || m_mode == 1;
    endfunction

    task automatic m_reset();
        m_mode = 0; m_cnt = 0; m_div = 4; m_pend = 4; m_err = 0;
    endtask

    task automatic m_step(input bit e, input bit v, input int d);
        bit take, ok, at_end;
        take = v && m_ready();
        ok = d >= 2;
        if (take && !ok) m_err = 1;
        at_end = m_mode != 0 && m_cnt == m_div - 1;
        if (m_mode == 0) begin
            if (take && ok) begin m_div = d; m_pend = d; end
            m_cnt = 0;
            if (e) m_mode = 1;
        end else begin
            m_cnt = at_end ? 0 : m_cnt + 1;
            if (m_mode == 1 && take && ok) begin
                m_pend = d;
                if (at_end) begin m_div = d; m_mode = e ? 1 : 0; end
                else m_mode = 2;
            end else if (at_end) begin
                m_div = m_pend;
                m_mode = (m_mode == 3 || !e) ? 0 : 1;
            end else if (m_mode == 1) m_mode = e ? 1 : 3;
            else if (m_mode == 2) m_mode = e ? 2 : 3;
            else m_mode = e ? 1 : 3;
        end
    endtask

    function automatic logic [12:0] m_expect();
        bit on;
        on = m_mode != 0;
        return {on && m_cnt < m_div / 2, on && m_cnt == 0, on, m_ready(), m_err, 8'(m_div)};
    endfunction

    function automatic logic [12:0] observed();
        return {clk_out, tick, busy, cfg_ready, err, cur_div};
    endfunction

    task automatic apply(input bit e, input bit v, input int d);
        en = e; cfg_valid = v; cfg_div = 8'(d);
        @(posedge clk);
        m_step(e, v, d);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_reset();
        en = 1'b0; cfg_valid = 1'b0;
        #12;
        reset = 1'b1;
        #1;
    endtask

    typedef struct {
        bit en, v;
        int d;
        logic [12:0] exp;
    } vec_t;
    vec_t tbl[18];

    function automatic vec_t mk(bit e, bit v, int d, bit c, bit t, bit b, bit r, int dv, bit er);
        vec_t x;
        x.en = e; x.v = v; x.d = d;
        x.exp = {c, t, b, r, er, 8'(dv)};
        return x;
    endfunction

    initial begin
        logic [7:0] pat_clk, pat_tick;
        bit hit;
        pat_clk = 8'b11001100;
        pat_tick = 8'b10001000;
        tbl[0]  = mk(0, 1, 5, 0, 0, 0, 1, 5, 0);
        tbl[1]  = mk(1, 0, 0, 1, 1, 1, 1, 5, 0);
        tbl[2]  = mk(1, 0, 0, 1, 0, 1, 1, 5, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 1, 1, 5, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 1, 1, 5, 0);
        tbl[5]  = mk(1, 0, 0, 0, 0, 1, 1, 5, 0);
        tbl[6]  = mk(1, 0, 0, 1, 1, 1, 1, 5, 0);
        tbl[7]  = mk(1, 1, 1, 1, 0, 1, 1, 5, 1);
        tbl[8]  = mk(1, 1, 6, 0, 0, 1, 0, 5, 1);
        tbl[9]  = mk(1, 0, 0, 0, 0, 1, 0, 5, 1);
        tbl[10] = mk(1, 0, 0, 0, 0, 1, 0, 5, 1);
        tbl[11] = mk(1, 0, 0, 1, 1, 1, 1, 6, 1);
        tbl[12] = mk(1, 0, 0, 1, 0, 1, 1, 6, 1);
        tbl[13] = mk(1, 0, 0, 1, 0, 1, 1, 6, 1);
        tbl[14] = mk(1, 0, 0, 0, 0, 1, 1, 6, 1);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 0, 6, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 1, 0, 6, 1);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 1, 6, 1);

        do_reset();
        chk("reset_state", observed(), {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4});

        foreach (tbl[i]) begin
            apply(tbl[i].en, tbl[i].v, tbl[i].d);
            chk($sformatf("table[%0d]", i), observed(), tbl[i].exp);
        end

        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(1, 0, 0);
            chk($sformatf("default_pattern[%0d]", i), {clk_out, tick, busy},
                {pat_clk[7-i], pat_tick[7-i], 1'b1});
        end

        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            apply(1, 0, 0);
            hit = tick && clk_out;
        end
        chk("reach_period_start", 32'(hit), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_clk_out", {clk_out, tick, busy}, 3'b000);
        do_reset();

`ifdef CLKDIV_PERIOD_CNT_EN
        for (int i = 0; i < 40; i++) apply(1, 0, 0);
        chk("period_cnt_10", 32'(period_cnt), 32'd10);
        do_reset();
`endif

        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9));
            chk($sformatf("random[%0d]", i), observed(), m_expect());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
